cbus_arbiter: RTL and testbench
===============================

Name: cbus_arbiter

Overview:
Shares one cache-bus (CBus) master port between NUM_REQ requesters, e.g. the CPU instruction fetch and data access ports. The shared port feeds the CBus-to-AXI converter in the non-fixed-latency top.
- Round-robin grant.
- The grant is locked for a whole transaction, including multi-beat bursts.
- One-cycle registered arbitration latency.
- Responses are routed back only to the granted requester.

Parameters:
NUM_REQ, 2, number of requesters (>=2); index 0 = instruction bus, 1 = data bus in the default core build.
IDX_W, $clog2(NUM_REQ), grant index width (derived, not overridden).

Ports:
clk  in  1  core clock.
resetn  in  1  asynchronous active-low reset.
ireqs  in  NUM_REQ x cbus_req_t (77b each)  requester requests.
iresps  out  NUM_REQ x cbus_resp_t (34b each)  per-requester responses.
oreq  out  cbus_req_t  shared request toward the converter.
oresp  in  cbus_resp_t  shared response from the converter.

cbus_req_t fields, MSB first:
- valid 1
- is_write 1
- size 3
- addr 32
- strobe 4
- data 32
- len 4 (beats-1)

cbus_resp_t fields, MSB first:
- ready 1
- last 1
- data 32

Behaviour:
- Reset (async assert, sync deassert by top):
  - state=IDLE, sel=0, last_grant=NUM_REQ-1, so index 0 wins first.
  - oreq='0 and all iresps='0, effective immediately on assert.
- IDLE:
  - oreq='0 and iresps all '0.
  - If any ireqs[i].valid: pick the first valid index scanning last_grant+1, last_grant+2, ... modulo NUM_REQ (wrap-around).
  - Register the pick into sel; next state BUSY.
  - No valid requester: stay IDLE.
- BUSY:
  - oreq=ireqs[sel] (pass-through, combinational).
  - iresps[sel]=oresp; all other iresps='0 (ready=0).
- End of transaction:
  - On oresp.ready && oresp.last: last_grant<=sel, next state IDLE.
  - A requester's next request is therefore arbitrated no earlier than the cycle after the last beat. Minimum gap between back-to-back grants is 1 IDLE cycle.
- Latency: request valid at cycle N (arbiter IDLE) -> oreq.valid at N+1.
- Burst: the grant is held across all len+1 beats. Beats with ready && !last do not release the grant.
- Simultaneous requests: exactly one is granted; the loser keeps valid asserted and sees ready=0 until its own grant.
- Protocol requirements:
  - Requesters hold valid and all request fields stable from assertion until the last-beat handshake.
  - A valid drop while granted is a protocol violation. The arbiter does not release the grant early; simulation asserts flag it.
- oresp.ready while IDLE is ignored; the simulation assert flags it.
- Reset mid-transaction: state->IDLE immediately; oreq.valid=0 the same cycle. The downstream converter is reset by the same resetn.
- Widths: sel/last_grant are IDX_W bits; the modulo wrap is explicit for non-power-of-2 NUM_REQ.

Decomposition:
- cbus_req_t, cbus_resp_t, CBUS_* field widths and the arbiter state enum (IDLE, BUSY) go in the shared common package header.
- One natural sub-module: rr_picker. It is combinational and takes valid vector + last_grant, returning any_valid and a pick index.

Test Plan:
1. Reset, then only ireqs[1] valid, single-beat read addr 0xBFC00000, len=0. Expect:
   - oreq.valid=1 one cycle later with addr 0xBFC00000.
   - iresps[1].data=0xDEADBEEF on the ready&last beat.
   - iresps[0].ready never 1.
2. Both valid at the same cycle after reset. Expect:
   - Index 0 served first.
   - After its last beat, one IDLE cycle, then index 1 granted.
   - Next tie grants index 1 before 0 (round-robin).
3. ireqs[0] 4-beat burst (len=3) while ireqs[1] stays valid. Expect:
   - Grant stays 0 for all 4 beats, including beats with ready=1, last=0.
   - Index 1 is granted only after beat 4.
4. Write from ireqs[1], strobe=4'b0011, data=0x12345678. Expect oreq carries is_write=1, strobe=0011, data unchanged.
5. Assert resetn=0 mid-burst (beat 2 of 4). Expect:
   - oreq.valid=0 and iresps '0 in the same cycle.
   - After release, arbitration restarts with index 0 priority.
6. No requests for 10 cycles, including stray oresp.ready=1. Expect oreq.valid stays 0 and the state stays IDLE.

Source files
------------

// File: rtl/cbus_arbiter_pkg.sv
// Shared CBus types, field widths and arbiter state constants used by the
// arbiter and its round-robin picker.
package cbus_arbiter_pkg;

    localparam int CBUS_SIZE_W = 3;
    localparam int CBUS_ADDR_W = 32;
    localparam int CBUS_STRB_W = 4;
    localparam int CBUS_DATA_W = 32;
    localparam int CBUS_LEN_W  = 4;

    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        logic [CBUS_SIZE_W-1:0] size;
        logic [CBUS_ADDR_W-1:0] addr;
        logic [CBUS_STRB_W-1:0] strobe;
        logic [CBUS_DATA_W-1:0] data;
        logic [CBUS_LEN_W-1:0]  len;     // beats - 1
    } cbus_req_t;

    typedef struct packed {
        logic                   ready;
        logic                   last;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_resp_t;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

endpackage

// File: rtl/cbus_arbiter_rr_picker.sv
// Round-robin picker: first valid index after last_grant_i, wrapping
// explicitly so non-power-of-2 requester counts work.
module cbus_arbiter_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic               any_valid_o,
    output logic [IDX_W-1:0]   pick_o
);

    int         idx;
    logic [IDX_W-1:0] idx_w;

    // NOTE: every output and temporary gets a default first so no path
    // through this block leaves a value unassigned and infers a latch.
    always_comb begin
        any_valid_o = 1'b0;
        pick_o      = '0;
        idx         = 0;
        idx_w       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant_i) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_w = IDX_W'(idx);
            if (!any_valid_o && valid_i[idx_w]) begin
                any_valid_o = 1'b1;
                pick_o      = idx_w;
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one CBus master port among NUM_REQ requesters;
// the grant is registered and held for the whole transaction.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  cbus_req_t  [NUM_REQ-1:0]  ireqs,
    output cbus_resp_t [NUM_REQ-1:0]  iresps,
    output cbus_req_t                 oreq,
    input  cbus_resp_t                oresp
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0] valid_vec;
    logic             any_valid;
    logic [IDX_W-1:0] pick;

    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) valid_vec[i] = ireqs[i].valid;
    end

    cbus_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid_i      (valid_vec),
        .last_grant_i (last_grant_q),
        .any_valid_o  (any_valid),
        .pick_o       (pick)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ARB_IDLE: if (any_valid) begin
                sel_d   = pick;
                state_d = ARB_BUSY;
            end
            ARB_BUSY: if (oresp.ready && oresp.last) begin
                last_grant_d = sel_q;
                state_d      = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ARB_IDLE;
            sel_q        <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Outputs decode from state_q, so an async reset silences them at once.
    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (state_q == ARB_BUSY) begin
            oreq          = ireqs[sel_q];
            iresps[sel_q] = oresp;
        end
    end

    a_valid_held: assert property (@(posedge clk) disable iff (!resetn)
        (state_q == ARB_BUSY) |-> ireqs[sel_q].valid)
        else $warning("cbus_arbiter: granted requester dropped valid before last beat");

    a_idle_ready: assert property (@(posedge clk) disable iff (!resetn)
        (state_q == ARB_IDLE) |-> !oresp.ready)
        else $warning("cbus_arbiter: oresp.ready while idle is ignored");

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed plus randomized bench for cbus_arbiter, checked every cycle against
// a transaction-level round-robin ownership model.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int N = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    cbus_req_t  [N-1:0] ireqs;
    cbus_resp_t [N-1:0] iresps;
    cbus_req_t          oreq;
    cbus_resp_t         oresp;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the bus (-1 = nobody) and who owned it last.
    int m_owner  = -1;
    int m_last   = N - 1;
    int beat     = 0;
    int done_idx = -1;

    always #5 clk = ~clk;

    cbus_arbiter #(.NUM_REQ(N)) dut (
        .clk    (clk),
        .resetn (resetn),
        .ireqs  (ireqs),
        .iresps (iresps),
        .oreq   (oreq),
        .oresp  (oresp)
    );

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_winner(int last);
        for (int k = 1; k <= N; k++)
            if (ireqs[(last + k) % N].valid) return (last + k) % N;
        return -1;
    endfunction

    function automatic cbus_req_t mk(bit wr, logic [31:0] addr, logic [3:0] strb,
                                     logic [31:0] data, logic [3:0] len);
        cbus_req_t r;
        r.valid = 1'b1; r.is_write = wr; r.size = 3'd2; r.addr = addr;
        r.strobe = strb; r.data = data; r.len = len;
        return r;
    endfunction

    task automatic resp(bit r, bit l, logic [31:0] d);
        oresp.ready = r; oresp.last = l; oresp.data = d;
    endtask

    task automatic apply_reset();
        resetn = 1'b0; m_owner = -1; m_last = N - 1; beat = 0;
    endtask

    // Compare all outputs with the model, shortly after inputs change.
    task automatic settle();
        cbus_req_t  e_req;
        cbus_resp_t e_resp;
        #1;
        e_req = (m_owner >= 0) ? ireqs[m_owner] : '0;
        check("oreq", 128'(oreq), 128'(e_req));
        for (int i = 0; i < N; i++) begin
            e_resp = (i == m_owner) ? oresp : '0;
            check($sformatf("iresps[%0d]", i), 128'(iresps[i]), 128'(e_resp));
        end
    endtask

    // Advance the model with the current inputs, then cross one clock edge.
    task automatic advance();
        done_idx = -1;
        if (!resetn) begin
            m_owner = -1; m_last = N - 1; beat = 0;
        end else if (m_owner < 0) begin
            m_owner = rr_winner(m_last); beat = 0;
        end else if (oresp.ready) begin
            if (oresp.last) begin
                m_last = m_owner; done_idx = m_owner; m_owner = -1; beat = 0;
            end else beat++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit r;
        ireqs = '0;
        oresp = '0;
        resetn = 1'b0;

        // Reset state
        @(negedge clk);
        settle();
        advance();
        resetn = 1'b1;

        // 1: single-beat read from requester 1
        ireqs[1] = mk(1'b0, 32'hBFC0_0000, 4'hF, 32'h0, 4'd0);
        resp(0, 0, 0);
        settle();
        check("t1_same_cycle_valid", 128'(oreq.valid), 128'(1'b0));
        advance();
        resp(1, 1, 32'hDEAD_BEEF);
        settle();
        check("t1_valid", 128'(oreq.valid), 128'(1'b1));
        check("t1_addr", 128'(oreq.addr), 128'(32'hBFC0_0000));
        check("t1_data", 128'(iresps[1].data), 128'(32'hDEAD_BEEF));
        check("t1_other_ready", 128'(iresps[0].ready), 128'(1'b0));
        advance();
        ireqs[1] = '0;
        resp(0, 0, 0);
        settle();
        advance();

        // 2: simultaneous requests, then a round-robin tie
        ireqs[0] = mk(1'b0, 32'h0000_1000, 4'hF, 32'h0, 4'd0);
        ireqs[1] = mk(1'b0, 32'h0000_2000, 4'hF, 32'h0, 4'd0);
        settle();
        advance();
        resp(1, 1, 32'hA0);
        settle();
        check("t2_first", 128'(oreq.addr), 128'(32'h0000_1000));
        advance();
        ireqs[0] = mk(1'b0, 32'h0000_3000, 4'hF, 32'h0, 4'd0);
        resp(0, 0, 0);
        settle();
        check("t2_gap", 128'(oreq.valid), 128'(1'b0));
        advance();
        resp(1, 1, 32'hA1);
        settle();
        check("t2_rr_tie", 128'(oreq.addr), 128'(32'h0000_2000));
        advance();
        ireqs[1] = '0;
        resp(0, 0, 0);
        settle();
        advance();
        resp(1, 1, 32'hA2);
        settle();
        check("t2_third", 128'(oreq.addr), 128'(32'h0000_3000));
        advance();
        ireqs[0] = '0;
        resp(0, 0, 0);

        // 4: write pass-through from requester 1
        ireqs[1] = mk(1'b1, 32'h0000_4000, 4'b0011, 32'h1234_5678, 4'd0);
        settle();
        advance();
        resp(1, 1, 32'h0);
        settle();
        check("t4_is_write", 128'(oreq.is_write), 128'(1'b1));
        check("t4_strobe", 128'(oreq.strobe), 128'(4'b0011));
        check("t4_data", 128'(oreq.data), 128'(32'h1234_5678));
        advance();
        ireqs[1] = '0;
        resp(0, 0, 0);

        // 3: 4-beat burst from 0 while 1 waits
        ireqs[0] = mk(1'b0, 32'h0000_5000, 4'hF, 32'h0, 4'd3);
        ireqs[1] = mk(1'b0, 32'h0000_6000, 4'hF, 32'h0, 4'd0);
        settle();
        advance();
        settle();
        check("t3_wait", 128'(oreq.addr), 128'(32'h0000_5000));
        advance();
        for (int b = 0; b < 4; b++) begin
            resp(1, b == 3, 32'(b));
            settle();
            check($sformatf("t3_hold_b%0d", b), 128'(oreq.addr), 128'(32'h0000_5000));
            check($sformatf("t3_loser_b%0d", b), 128'(iresps[1].ready), 128'(1'b0));
            advance();
        end
        ireqs[0] = '0;
        resp(0, 0, 0);
        settle();
        check("t3_gap", 128'(oreq.valid), 128'(1'b0));
        advance();
        resp(1, 1, 32'h0);
        settle();
        check("t3_next", 128'(oreq.addr), 128'(32'h0000_6000));
        advance();
        ireqs[1] = '0;
        resp(0, 0, 0);

        // 5: reset in the middle of a burst
        ireqs[0] = mk(1'b0, 32'h0000_7000, 4'hF, 32'h0, 4'd3);
        ireqs[1] = mk(1'b0, 32'h0000_8000, 4'hF, 32'h0, 4'd0);
        settle();
        advance();
        resp(1, 0, 32'h0);
        settle();
        advance();
        resp(1, 0, 32'h1);
        apply_reset();
        settle();
        check("t5_rst_valid", 128'(oreq.valid), 128'(1'b0));
        check("t5_rst_resp0", 128'(iresps[0]), 128'(0));
        advance();
        resetn = 1'b1;
        resp(0, 0, 0);
        settle();
        advance();
        settle();
        check("t5_restart", 128'(oreq.addr), 128'(32'h0000_7000));
        advance();
        for (int b = 0; b < 4; b++) begin
            resp(1, b == 3, 32'(b));
            settle();
            advance();
        end
        ireqs[0] = '0;
        resp(0, 0, 0);
        settle();
        advance();
        resp(1, 1, 32'h0);
        settle();
        check("t5_then_1", 128'(oreq.addr), 128'(32'h0000_8000));
        advance();
        ireqs[1] = '0;

        // 6: idle with stray ready
        for (int c = 0; c < 10; c++) begin
            resp(1'($urandom), 1'($urandom), $urandom);
            settle();
            check("t6_idle", 128'(oreq.valid), 128'(1'b0));
            advance();
        end
        resp(0, 0, 0);

        // Randomized traffic against the ownership model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!ireqs[i].valid && $urandom_range(0, 2) == 0)
                    ireqs[i] = mk(1'($urandom), $urandom, 4'($urandom), $urandom,
                                  4'($urandom_range(0, 3)));
            if (m_owner >= 0) begin
                r = ($urandom_range(0, 3) != 0);
                resp(r, r && (beat == int'(ireqs[m_owner].len)), $urandom);
            end else begin
                resp(0, 0, 0);
            end
            settle();
            advance();
            if (done_idx >= 0) ireqs[done_idx] = '0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
